adres_vliw_rf: RTL and testbench

- Local register file for one ADRES VLIW functional unit.
- Consumes the FU result `fu_to_rf` and produces `rf_to_muxa` and `rf_to_muxout`.
  - `rf_to_muxa` feeds the FU operand-A mux.
  - `rf_to_muxout` feeds the FU output mux.
- Holds NUM_CTX per-context configuration words, loaded by a serial chain on the datapath clock.
- A context sequencer steps through the active contexts (the schedule's II) each run cycle.

---
 rtl/adres_rf_pkg.sv | 41 ++++
 rtl/adres_rf_config_chain.sv | 78 +++++++
 rtl/adres_vliw_rf.sv | 88 ++++++++
 tb/tb_adres_vliw_rf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adres_rf_pkg.sv
// Shared sizing helpers, context-word field offsets and the decoded context word
// used by the ADRES VLIW local register file.
package adres_rf_pkg;

  // Widest register address a decoded context word can carry (up to 256 registers).
  localparam int AW_MAX    = 8;
  localparam int WE_BIT    = 0;
  localparam int WADDR_LSB = 1;

  function automatic int aw_of(input int num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int cw_of(input int num_regs);
    return 1 + 3 * $clog2(num_regs);
  endfunction

  function automatic int ctxw_of(input int num_ctx);
    return $clog2(num_ctx + 1);
  endfunction

  function automatic int cxw_of(input int num_ctx);
    return (num_ctx > 1) ? $clog2(num_ctx) : 1;
  endfunction

  function automatic int ra_lsb(input int aw);
    return WADDR_LSB + aw;
  endfunction

  function automatic int rb_lsb(input int aw);
    return WADDR_LSB + 2 * aw;
  endfunction

  typedef struct packed {
    logic [AW_MAX-1:0] raddr_b;
    logic [AW_MAX-1:0] raddr_a;
    logic [AW_MAX-1:0] waddr;
    logic              we;
  } ctx_word_t;

endpackage

// File: rtl/adres_rf_config_chain.sv
// Serial configuration chain holding NUM_CTX context words, plus the context
// sequencer that walks the first ii contexts on every run cycle.
module adres_rf_config_chain
  import adres_rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int NUM_CTX  = 4,
  localparam int AW      = aw_of(NUM_REGS),
  localparam int CW      = cw_of(NUM_REGS),
  localparam int CTXW    = ctxw_of(NUM_CTX),
  localparam int CXW     = cxw_of(NUM_CTX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            config_in,
  output logic            config_out,
  input  logic            config_shift,
  input  logic            run,
  input  logic [CTXW-1:0] ii,
  output ctx_word_t       word,
  output logic [CXW-1:0]  ctx
);

  localparam int L     = NUM_CTX * CW;
  localparam int RA_LO = ra_lsb(AW);
  localparam int RB_LO = rb_lsb(AW);

  logic [L-1:0]    chain_reg;
  logic [CXW-1:0]  ctx_reg;
  logic [CTXW-1:0] ii_eff;
  logic [CTXW-1:0] ctx_ext;
  logic            ctx_wrap;
  logic [CW-1:0]   ctx_words [NUM_CTX];
  logic [CW-1:0]   raw_word;

  for (genvar gi = 0; gi < NUM_CTX; gi++) begin : g_word
    assign ctx_words[gi] = chain_reg[gi*CW +: CW];
  end

  always_comb begin
    ii_eff = ii;
    if (ii == '0 || ii > CTXW'(NUM_CTX)) ii_eff = CTXW'(NUM_CTX);
  end

  // Using >= also wraps a ctx left stranded above a freshly lowered ii.
  assign ctx_ext  = CTXW'(ctx_reg);
  assign ctx_wrap = (ctx_ext >= ii_eff - CTXW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
      ctx_reg   <= '0;
    end else if (config_shift) begin
      chain_reg <= {chain_reg[L-2:0], config_in};
    end else if (run) begin
      ctx_reg <= ctx_wrap ? '0 : ctx_reg + CXW'(1);
    end
  end

  always_comb begin
    raw_word = ctx_words[0];
    for (int k = 1; k < NUM_CTX; k++) begin
      if (ctx_reg == CXW'(k)) raw_word = ctx_words[k];
    end
  end

  always_comb begin
    word                 = '0;
    word.we              = raw_word[WE_BIT];
    word.waddr[AW-1:0]   = raw_word[WADDR_LSB +: AW];
    word.raddr_a[AW-1:0] = raw_word[RA_LO +: AW];
    word.raddr_b[AW-1:0] = raw_word[RB_LO +: AW];
  end

  assign config_out = chain_reg[L-1];
  assign ctx        = ctx_reg;

endmodule

// File: rtl/adres_vliw_rf.sv
// ADRES VLIW functional-unit local register file: register array, write port and
// two context-addressed read ports. Define ADRES_RF_ZERO_REG_EN to hardwire r0 to zero.
module adres_vliw_rf
  import adres_rf_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int NUM_REGS = 8,
  parameter int NUM_CTX  = 4,
  localparam int CTXW    = ctxw_of(NUM_CTX),
  localparam int CXW     = cxw_of(NUM_CTX)
) (
  input  logic            CGRA_Clock,
  input  logic            CGRA_Reset,
  input  logic            ConfigIn,
  output logic            ConfigOut,
  input  logic            config_shift,
  input  logic            run,
  input  logic [CTXW-1:0] ii,
  input  logic [SIZE-1:0] fu_to_rf,
  output logic [SIZE-1:0] rf_to_muxa,
  output logic [SIZE-1:0] rf_to_muxout,
  output logic [CXW-1:0]  ctx
);

`ifdef ADRES_RF_ZERO_REG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  ctx_word_t       word;
  logic            wr_en;
  logic [SIZE-1:0] reg_val [NUM_REGS];
  logic [SIZE-1:0] rd_a;
  logic [SIZE-1:0] rd_b;

  adres_rf_config_chain #(
    .NUM_REGS (NUM_REGS),
    .NUM_CTX  (NUM_CTX)
  ) u_chain (
    .clk          (CGRA_Clock),
    .rst          (CGRA_Reset),
    .config_in    (ConfigIn),
    .config_out   (ConfigOut),
    .config_shift (config_shift),
    .run          (run),
    .ii           (ii),
    .word         (word),
    .ctx          (ctx)
  );

  // A shift cycle never writes, even when run is also asserted.
  assign wr_en = run && !config_shift;

`ifdef ADRES_RF_ZERO_REG_EN
  assign reg_val[0] = '0;
`endif

  for (genvar gi = FIRST; gi < NUM_REGS; gi++) begin : g_reg
    logic [SIZE-1:0] q_reg;
    logic            hit;

    assign hit = wr_en && word.we && (word.waddr == AW_MAX'(gi));

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
      if (CGRA_Reset) begin
        q_reg <= '0;
      end else if (hit) begin
        q_reg <= fu_to_rf;
      end
    end

    assign reg_val[gi] = q_reg;
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word.raddr_a == AW_MAX'(i)) rd_a = reg_val[i];
      if (word.raddr_b == AW_MAX'(i)) rd_b = reg_val[i];
    end
  end

  assign rf_to_muxa   = rd_a;
  assign rf_to_muxout = rd_b;

endmodule

// File: tb/tb_adres_vliw_rf.sv
// Directed self-checking bench for adres_vliw_rf at default parameters
// (SIZE=32, NUM_REGS=8, NUM_CTX=4, CW=10, chain length 40).
module tb_adres_vliw_rf;

`ifdef ADRES_RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        config_in = 1'b0;
  logic        config_out;
  logic        config_shift = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  ii = 3'd0;
  logic [31:0] fu = 32'd0;
  logic [31:0] muxa;
  logic [31:0] muxout;
  logic [1:0]  ctx;

  int checks = 0;
  int errors = 0;

  // ctx3=0x181 {we,w0,ra0,rb3}, ctx2=0x1D0 {ra5,rb3}, ctx1=0x2BB {we,w5,ra3,rb5}, ctx0=0x037 {we,w3,ra3,rb0}
  logic [39:0] cfg_a;
  // ctx k: no write, ra=k, rb=k+4
  logic [39:0] cfg_b;

  always #5 clk = ~clk;

  adres_vliw_rf dut (
    .CGRA_Clock   (clk),
    .CGRA_Reset   (rst),
    .ConfigIn     (config_in),
    .ConfigOut    (config_out),
    .config_shift (config_shift),
    .run          (run),
    .ii           (ii),
    .fu_to_rf     (fu),
    .rf_to_muxa   (muxa),
    .rf_to_muxout (muxout),
    .ctx          (ctx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [39:0] v);
    run = 1'b0;
    config_shift = 1'b1;
    for (int i = 39; i >= 0; i--) begin
      config_in = v[i];
      tick();
    end
    config_shift = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] d);
    fu = d;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL reset_ctx: got %0d expected 0", ctx); end
    checks++; if (muxa !== 32'd0) begin errors++; $display("FAIL reset_muxa: got %h expected 0", muxa); end
    checks++; if (muxout !== 32'd0) begin errors++; $display("FAIL reset_muxout: got %h expected 0", muxout); end
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL reset_configout: got %b expected 0", config_out); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_config_wrap();
    load_cfg(cfg_a);
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL cfg_ctx_held: got %0d expected 0", ctx); end
    config_shift = 1'b1;
    config_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (config_out !== cfg_a[39-i]) begin
        errors++; $display("FAIL cfg_replay bit %0d: got %b expected %b", i, config_out, cfg_a[39-i]);
      end
      tick();
    end
    config_shift = 1'b0;
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL cfg_drained: got %b expected 0", config_out); end
    load_cfg(cfg_a);
    $display("test_config_wrap done");
  endtask

  task automatic test_write_latency();
    ii = 3'd1;
    fu = 32'hDEADBEEF;
    run = 1'b1;
    checks++; if (muxa !== 32'd0) begin errors++; $display("FAIL wr_old_value: got %h expected 00000000", muxa); end
    tick();
    run = 1'b0;
    checks++; if (muxa !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_new_value: got %h expected deadbeef", muxa); end
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL wr_ii1_hold: got %0d expected 0", ctx); end
    checks++; if (muxout !== 32'd0) begin errors++; $display("FAIL wr_rb0: got %h expected 0", muxout); end
    $display("test_write_latency done");
  endtask

  task automatic test_sequencing();
    logic [1:0]  exp3 [9] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [1:0]  exp4 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] dat  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ii = 3'd3;
    for (int i = 0; i < 9; i++) begin
      pulse(32'd0);
      checks++; if (ctx !== exp3[i]) begin errors++; $display("FAIL seq_ii3 step %0d: got %0d expected %0d", i, ctx, exp3[i]); end
    end
    ii = 3'd5;
    for (int i = 0; i < 4; i++) begin
      pulse(32'd0);
      checks++; if (ctx !== exp4[i]) begin errors++; $display("FAIL seq_ii5 step %0d: got %0d expected %0d", i, ctx, exp4[i]); end
    end
    ii = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pulse(dat[i]);
      checks++; if (ctx !== exp4[i]) begin errors++; $display("FAIL seq_ii0 step %0d: got %0d expected %0d", i, ctx, exp4[i]); end
    end
    checks++; if (muxa !== 32'h11111111) begin errors++; $display("FAIL seq_r3: got %h expected 11111111", muxa); end
    checks++; if (muxout !== (ZR ? 32'd0 : 32'h44444444)) begin
      errors++; $display("FAIL seq_r0: got %h expected %h", muxout, ZR ? 32'd0 : 32'h44444444);
    end
    $display("test_sequencing done");
  endtask

  task automatic test_ii_change();
    ii = 3'd2;
    pulse(32'hABCD0001);
    checks++; if (ctx !== 2'd1) begin errors++; $display("FAIL iic_ctx1: got %0d expected 1", ctx); end
    checks++; if (muxa !== 32'hABCD0001) begin errors++; $display("FAIL iic_r3: got %h expected abcd0001", muxa); end
    checks++; if (muxout !== 32'h22222222) begin errors++; $display("FAIL iic_r5: got %h expected 22222222", muxout); end
    fu = 32'hFFFFFFFF;
    tick(); tick(); tick();
    checks++; if (ctx !== 2'd1) begin errors++; $display("FAIL idle_ctx: got %0d expected 1", ctx); end
    checks++; if (muxout !== 32'h22222222) begin errors++; $display("FAIL idle_r5: got %h expected 22222222", muxout); end
    ii = 3'd1;
    pulse(32'h66666666);
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL iic_wrap: got %0d expected 0", ctx); end
    ii = 3'd2;
    pulse(32'h77777777);
    checks++; if (muxa !== 32'h77777777) begin errors++; $display("FAIL iic_r3b: got %h expected 77777777", muxa); end
    checks++; if (muxout !== 32'h66666666) begin errors++; $display("FAIL iic_r5b: got %h expected 66666666", muxout); end
    $display("test_ii_change done");
  endtask

  task automatic test_shift_priority();
    fu = 32'hDEADDEAD;
    config_in = 1'b1;
    config_shift = 1'b1;
    run = 1'b1;
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL prio_pre_cfgout: got %b expected 0", config_out); end
    tick();
    config_shift = 1'b0;
    run = 1'b0;
    checks++; if (ctx !== 2'd1) begin errors++; $display("FAIL prio_ctx: got %0d expected 1", ctx); end
    checks++; if (config_out !== 1'b1) begin errors++; $display("FAIL prio_shifted: got %b expected 1", config_out); end
    load_cfg(cfg_a);
    checks++; if (ctx !== 2'd1) begin errors++; $display("FAIL prio_ctx_after_load: got %0d expected 1", ctx); end
    checks++; if (muxout !== 32'h66666666) begin errors++; $display("FAIL prio_no_write: got %h expected 66666666", muxout); end
    checks++; if (muxa !== 32'h77777777) begin errors++; $display("FAIL prio_r3: got %h expected 77777777", muxa); end
    $display("test_shift_priority done");
  endtask

  task automatic test_zero_reg();
    ii = 3'd0;
    pulse(32'h5);
    pulse(32'h0);
    checks++; if (ctx !== 2'd3) begin errors++; $display("FAIL zr_ctx3: got %0d expected 3", ctx); end
    pulse(32'h12345678);
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL zr_ctx0: got %0d expected 0", ctx); end
    checks++; if (muxout !== (ZR ? 32'd0 : 32'h12345678)) begin
      errors++; $display("FAIL zr_read_rb: got %h expected %h", muxout, ZR ? 32'd0 : 32'h12345678);
    end
    checks++; if (muxa !== 32'h77777777) begin errors++; $display("FAIL zr_r3: got %h expected 77777777", muxa); end
    pulse(32'h1);
    pulse(32'h2);
    pulse(32'h3);
    checks++; if (muxa !== (ZR ? 32'd0 : 32'h12345678)) begin
      errors++; $display("FAIL zr_read_ra: got %h expected %h", muxa, ZR ? 32'd0 : 32'h12345678);
    end
    checks++; if (muxout !== 32'h1) begin errors++; $display("FAIL zr_r3_new: got %h expected 00000001", muxout); end
    $display("test_zero_reg done");
  endtask

  task automatic test_reset_mid_run();
    config_shift = 1'b1;
    config_in = 1'b0;
    tick();
    config_shift = 1'b0;
    checks++; if (config_out !== 1'b1) begin errors++; $display("FAIL rst_pre_cfgout: got %b expected 1", config_out); end
    fu = 32'hAAAA5555;
    run = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (ctx !== 2'd0) begin errors++; $display("FAIL rst_async_ctx: got %0d expected 0", ctx); end
    checks++; if (muxa !== 32'd0) begin errors++; $display("FAIL rst_async_muxa: got %h expected 0", muxa); end
    checks++; if (muxout !== 32'd0) begin errors++; $display("FAIL rst_async_muxout: got %h expected 0", muxout); end
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL rst_async_cfgout: got %b expected 0", config_out); end
    tick();
    run = 1'b0;
    rst = 1'b0;
    tick();
    load_cfg(cfg_b);
    ii = 3'd0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ctx !== 2'(k)) begin errors++; $display("FAIL rst_scan_ctx %0d: got %0d", k, ctx); end
      checks++; if (muxa !== 32'd0) begin errors++; $display("FAIL rst_scan_r%0d: got %h expected 0", k, muxa); end
      checks++; if (muxout !== 32'd0) begin errors++; $display("FAIL rst_scan_r%0d: got %h expected 0", k + 4, muxout); end
      pulse(32'hFFFFFFFF);
    end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    cfg_a = {10'h181, 10'h1D0, 10'h2BB, 10'h037};
    cfg_b = {10'h3B0, 10'h320, 10'h290, 10'h200};
    test_reset();
    test_config_wrap();
    test_write_latency();
    test_sequencing();
    test_ii_change();
    test_shift_priority();
    test_zero_reg();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
